// File: rtl/fractal_sync_tx_mux.sv
// fractal_sync_tx_mux: round-robin merge of N_PORTS response FIFO heads into one registered valid/ready link
module fractal_sync_tx_mux #(
  parameter type         fsync_rsp_t = logic,
  parameter int unsigned N_PORTS     = 2,
  localparam int unsigned IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_PORTS-1:0]     empty_i,
  input  fsync_rsp_t             rsp_i [N_PORTS],
  output logic [N_PORTS-1:0]     pop_o,
  output fsync_rsp_t             rsp_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IDX_W-1:0]       grant_o
);
  if (N_PORTS == 0) begin : g_bad_n_ports
    $fatal(1, "fractal_sync_tx_mux: N_PORTS must be >= 1");
  end
  logic [N_PORTS-1:0] req;
  logic [IDX_W-1:0]   ptr, win, idx, nxt_ptr;
  logic               load;
  assign req     = ~empty_i;
  assign load    = !rst_i && (!valid_o || ready_i) && |req;
  assign pop_o   = load ? N_PORTS'(1) << win : '0;
  assign nxt_ptr = (win == IDX_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr) + i) % int'(N_PORTS));
      win = req[idx] ? idx : win;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      rsp_o   <= '0;
      grant_o <= '0;
      ptr     <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      rsp_o   <= rsp_i[win];
      grant_o <= win;
      ptr     <= nxt_ptr;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fractal_sync_tx_mux.sv
// tb_fractal_sync_tx_mux: directed steps against a spec-level model and a per-transfer scoreboard
module tb_fractal_sync_tx_mux;
  typedef struct packed {
    logic       wake;
    logic [7:0] data;
  } rsp_t;
  typedef struct packed {
    logic [0:0] g;
    rsp_t       r;
  } exp_t;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] empty_i = 2'b11;
  rsp_t       rsp_i [2];
  logic [1:0] pop_o;
  rsp_t       rsp_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [0:0] grant_o;
  int         checks = 0;
  int         failures = 0;
  rsp_t       src_q [2][$];
  exp_t       sb [$];
  logic       m_valid = 1'b0;
  logic       m_ptr = 1'b0;
  logic       m_grant = 1'b0;
  rsp_t       m_rsp = '0;
  always #5 clk_i = ~clk_i;
  fractal_sync_tx_mux #(.fsync_rsp_t(rsp_t), .N_PORTS(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .empty_i (empty_i),
    .rsp_i   (rsp_i),
    .pop_o   (pop_o),
    .rsp_o   (rsp_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .grant_o (grant_o)
  );
  function automatic rsp_t mk(input logic wake, input logic [7:0] data);
    rsp_t r;
    r.wake = wake;
    r.data = data;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock cycle: drive inputs, check comb/registered outputs against the model, advance the model.
  task automatic cyc(input logic rst, input logic [1:0] mask, input logic rdy);
    logic [1:0] req;
    logic [1:0] ep;
    logic       load;
    int         w;
    exp_t       e;
    rst_i   = rst;
    ready_i = rdy;
    for (int k = 0; k < 2; k++) begin
      empty_i[k] = mask[k] || (src_q[k].size() == 0);
      rsp_i[k]   = (src_q[k].size() != 0) ? src_q[k][0] : '0;
    end
    #3;
    req  = ~empty_i;
    w    = req[m_ptr] ? int'(m_ptr) : (req[~m_ptr] ? int'(~m_ptr) : -1);
    load = !rst && (!m_valid || rdy) && (w >= 0);
    ep   = load ? (2'b01 << w) : 2'b00;
    chk("pop", 32'(pop_o), 32'(ep));
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("rsp", 32'(rsp_o), 32'(m_rsp));
    chk("grant", 32'(grant_o), 32'(m_grant));
    if (!rst && m_valid && rdy) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_grant", 32'(grant_o), 32'(e.g));
        chk("sb_rsp", 32'(rsp_o), 32'(e.r));
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_rsp   = '0;
      m_grant = 1'b0;
      m_ptr   = 1'b0;
      sb.delete();
    end else if (load) begin
      m_rsp   = src_q[w].pop_front();
      m_grant = 1'(w);
      m_valid = 1'b1;
      m_ptr   = (w == 1) ? 1'b0 : 1'b1;
      e.g     = 1'(w);
      e.r     = m_rsp;
      sb.push_back(e);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    rsp_i[0] = '0;
    rsp_i[1] = '0;
    @(posedge clk_i);
    #1;
    // Reset with both sources holding data: pop must stay 0.
    src_q[0].push_back(mk(1'b1, 8'h05));
    src_q[1].push_back(mk(1'b1, 8'hA0));
    cyc(1'b1, 2'b00, 1'b1);
    cyc(1'b1, 2'b00, 1'b1);
    // Single source.
    cyc(1'b0, 2'b10, 1'b1);
    chk("t2_valid", 32'(valid_o), 32'd1);
    chk("t2_rsp", 32'(rsp_o), 32'(mk(1'b1, 8'h05)));
    chk("t2_grant", 32'(grant_o), 32'd0);
    cyc(1'b0, 2'b01, 1'b1);
    chk("t2b_grant", 32'(grant_o), 32'd1);
    // Round robin, both sources busy.
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(mk(1'b0, 8'h10 + 8'(i)));
      src_q[1].push_back(mk(1'b1, 8'h20 + 8'(i)));
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'b00, 1'b1);
      chk("t3_grant_seq", 32'(grant_o), 32'(i % 2));
      chk("t3_valid", 32'(valid_o), 32'd1);
    end
    // Backpressure while 0x22 is held.
    src_q[0].push_back(mk(1'b0, 8'h22));
    src_q[1].push_back(mk(1'b0, 8'h33));
    cyc(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b00, 1'b0);
      chk("t4_rsp_hold", 32'(rsp_o.data), 32'h22);
    end
    cyc(1'b0, 2'b00, 1'b1);
    chk("t4_next", 32'(rsp_o.data), 32'h33);
    // Drain then idle; ptr must not move.
    cyc(1'b0, 2'b11, 1'b1);
    chk("t5_valid_fall", 32'(valid_o), 32'd0);
    cyc(1'b0, 2'b11, 1'b1);
    cyc(1'b0, 2'b11, 1'b0);
    src_q[0].push_back(mk(1'b1, 8'h55));
    src_q[1].push_back(mk(1'b1, 8'h44));
    cyc(1'b0, 2'b00, 1'b1);
    chk("t5_ptr_kept", 32'(grant_o), 32'd0);
    cyc(1'b0, 2'b00, 1'b1);
    chk("t5_src1", 32'(rsp_o.data), 32'h44);
    cyc(1'b0, 2'b11, 1'b1);
    // Reset in the middle of a round-robin stream.
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(mk(1'b0, 8'h60 + 8'(i)));
      src_q[1].push_back(mk(1'b1, 8'h70 + 8'(i)));
    end
    cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    chk("t6_valid_rst", 32'(valid_o), 32'd0);
    cyc(1'b0, 2'b00, 1'b1);
    chk("t6_first_grant", 32'(grant_o), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b11, 1'b1);
    cyc(1'b0, 2'b11, 1'b1);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
